// File: rtl/neurona_pkg.sv
// Shared definitions for the neurona neuron blocks.
//   state_e              : serial MAC controller states (S_ACC accept beats, S_OUT hold result)
//   clog2()              : ceil(log2(value)), used for counter sizing and width checks
//   NEURONA_CHECK_ACC_W  : elaboration-time check that the accumulator cannot overflow
`ifndef NEURONA_PKG_SV
`define NEURONA_PKG_SV

// Expands to a generate block that stops elaboration when ACC cannot hold
// bias + N products of an unsigned PIX-bit pixel by a signed WGT-bit weight.
`define NEURONA_CHECK_ACC_W(ACC, PIX, WGT, N) \
   if ((ACC) < (PIX) + (WGT) + 1 + neurona_pkg::clog2(N)) begin : g_acc_w_illegal \
      $error("neurona: ACC_W too small for PIX_W, WGT_W and N_INPUTS"); \
   end

package neurona_pkg;

   typedef enum logic {
      S_ACC = 1'b0,
      S_OUT = 1'b1
   } state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      r = 0;
      v = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

`endif

// File: rtl/neurona_sat.sv
// Combinational saturate-and-ReLU stage.
//   din  in  IN_W   signed value (IN_W >= OUT_W)
//   dout out OUT_W  din clamped to the signed OUT_W range; forced to 0 when negative and RELU=1
module neurona_sat #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 8,
   parameter int unsigned RELU  = 0
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout
);

   if (IN_W < OUT_W || OUT_W < 2) begin : g_width_illegal
      $error("neurona_sat: need IN_W >= OUT_W >= 2");
   end

   // Output range limits expressed at input width for a signed compare.
   localparam logic signed [IN_W-1:0] MaxV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MinV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [OUT_W-1:0] sat;

   always_comb begin
      if (din > MaxV) begin
         sat = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (din < MinV) begin
         sat = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         sat = din[OUT_W-1:0];
      end
      dout = sat;
      if (RELU != 0 && sat[OUT_W-1]) begin
         dout = '0;
      end
   end

endmodule

// File: rtl/neurona_mac_serial.sv
// Time-multiplexed neuron: one multiply-accumulate per accepted (pixel, weight) beat,
// bias added on the first beat, result saturated (and optionally ReLU'd) and returned
// over valid/ready.
//   clk, rst   clock, synchronous active-high reset (discards any partial frame)
//   bias       signed bias, sampled on the first accepted beat of a frame
//   in_valid / in_ready / in_pixel / in_weight / in_last   input beat stream
//   out_valid / out_ready / out_data / out_err             result handshake
//   out_err flags a frame whose in_last did not coincide with beat N_INPUTS.
module neurona_mac_serial
   import neurona_pkg::*;
#(
   parameter int unsigned N_INPUTS = 49,
   parameter int unsigned PIX_W    = 1,
   parameter int unsigned WGT_W    = 8,
   parameter int unsigned ACC_W    = 16,
   parameter int unsigned OUT_W    = 8,
   parameter int unsigned RELU     = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WGT_W-1:0] bias,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic        [PIX_W-1:0] in_pixel,
   input  logic signed [WGT_W-1:0] in_weight,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_err
);

   localparam int unsigned CntW  = clog2(N_INPUTS);
   localparam int unsigned ProdW = PIX_W + WGT_W + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(N_INPUTS - 1);

   if (N_INPUTS < 2) begin : g_n_inputs_illegal
      $error("neurona_mac_serial: N_INPUTS must be at least 2");
   end
   `NEURONA_CHECK_ACC_W(ACC_W, PIX_W, WGT_W, N_INPUTS)

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    err_q, err_d;

   logic                    accept;
   logic                    cnt_at_last;
   logic                    frame_end;
   logic signed [PIX_W:0]   pix_s;
   logic signed [ProdW-1:0] prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] bias_ext;

   // Pixel is unsigned: prepend a zero so the signed multiply treats it as positive.
   assign pix_s    = $signed({1'b0, in_pixel});
   assign prod     = ProdW'(pix_s) * ProdW'(in_weight);
   assign prod_ext = ACC_W'(prod);
   assign bias_ext = ACC_W'(bias);

   assign in_ready    = (state_q == S_ACC);
   assign out_valid   = (state_q == S_OUT);
   assign accept      = in_valid & in_ready;
   assign cnt_at_last = (cnt_q == LastCnt);
   // Close on whichever comes first: the sender's in_last or the N-th beat.
   assign frame_end   = in_last | cnt_at_last;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      err_d   = err_q;
      unique case (state_q)
         S_ACC: begin
            if (accept) begin
               acc_d = ((cnt_q == '0) ? bias_ext : acc_q) + prod_ext;
               if (frame_end) begin
                  state_d = S_OUT;
                  cnt_d   = '0;
                  err_d   = in_last ^ cnt_at_last;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_ACC;
            end
         end
         default: state_d = S_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_ACC;
         cnt_q   <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
      end
   end

   // acc is frozen in S_OUT, so out_data stays stable under back-pressure.
   neurona_sat #(
      .IN_W (ACC_W),
      .OUT_W(OUT_W),
      .RELU (RELU)
   ) u_sat (
      .din (acc_q),
      .dout(out_data)
   );

   assign out_err = err_q & out_valid;

endmodule
